// File: rtl/rom_fetch_buffer.sv
// Single-entry ROM word buffer: converts level-style mapper strobes into a
// req/ack memory transaction, and serves repeated same-word accesses from a one-word tag.
module rom_fetch_buffer #(
   parameter int ADDR_W = 24
) (
   input  logic              MCLK,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] ROM_ADDR,
   input  logic              ROM_CE_N,
   input  logic              ROM_OE_N,
   input  logic              ROM_WORD,
   output logic [15:0]       ROM_Q,
   input  logic              INVALIDATE,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_ACK,
   input  logic [15:0]       MEM_DATA,
   output logic              BUSY
);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:1] tag;
   logic              valid;
   logic              kill;
   logic [15:0]       data_buf;
   logic              a0;
   logic              w;
   logic              access;
   logic              hit;

   function automatic logic [15:0] fmt_lane(input logic [15:0] d,
                                            input logic        lane,
                                            input logic        word);
      logic [15:0] r;
      if (word)      r = d;
      else if (lane) r = {d[15:8], d[15:8]};
      else           r = {d[7:0], d[7:0]};
      return r;
   endfunction

   assign access = ~ROM_CE_N & ~ROM_OE_N;
   assign hit    = access & valid & (ROM_ADDR[ADDR_W-1:1] == tag);

   // Request is decoded from state so it drops the instant reset asserts.
   assign MEM_REQ = (state == S_REQ);
   assign BUSY    = MEM_REQ;

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (access && !hit) state_d = S_REQ;
         S_REQ:   if (MEM_ACK)        state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ROM_Q    <= '0;
         MEM_ADDR <= '0;
         tag      <= '0;
         valid    <= 1'b0;
         kill     <= 1'b0;
         data_buf <= '0;
         a0       <= 1'b0;
         w        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (INVALIDATE) valid <= 1'b0;
               if (hit) begin
                  ROM_Q <= fmt_lane(data_buf, ROM_ADDR[0], ROM_WORD);
               end else if (access) begin
                  MEM_ADDR <= {ROM_ADDR[ADDR_W-1:1], 1'b0};
                  a0       <= ROM_ADDR[0];
                  w        <= ROM_WORD;
               end
            end
            S_REQ: begin
               if (INVALIDATE) kill <= 1'b1;
               // A fill that raced an invalidate still answers the mapper but is not cached.
               if (MEM_ACK) begin
                  data_buf <= MEM_DATA;
                  tag      <= MEM_ADDR[ADDR_W-1:1];
                  valid    <= ~(kill | INVALIDATE);
                  ROM_Q    <= fmt_lane(MEM_DATA, a0, w);
                  kill     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
